stop_watch_lap: RTL and testbench
=================================

// Module: stop_watch_lap
// PURPOSE
// - Parametrised successor stopwatch: HH:MM:SS.cc BCD timekeeper with on-chip tick divider, debounced buttons and lap FIFO.
// - Runs on system clk; no derived clocks. Feeds the 8-digit seven-segment driver (time_bcd) and lap readout logic (lap_*).
// PARAMETERS
// - CLK_HZ          100_000_000  system clock frequency
// - TICK_HZ         100          count rate; DIV = CLK_HZ/TICK_HZ, must be integer >= 2
// - DEBOUNCE_CYCLES 1_000_000    cycles a synced button level must hold before it is accepted (>= 2)
// - LAP_DEPTH       4            lap FIFO entries; power of two, >= 2
// PORTS
// - clk             in   1   system clock; all state on posedge
// - reset_n         in   1   asynchronous, active-low reset
// - start_stop_btn  in   1   raw async button, active-high; press toggles run/stop
// - lap_btn         in   1   raw async button; press = lap capture if running, time clear if stopped
// - lap_rd          in   1   pop request; one lap entry per cycle while lap_valid
// - time_bcd        out  32  {H1,H0,M1,M0,S1,S0,c1,c0} BCD nibbles
// - running         out  1   1 = counting
// - lap_bcd         out  32  FIFO head, same format as time_bcd; valid when lap_valid
// - lap_valid       out  1   FIFO not empty
// - lap_count       out  $clog2(LAP_DEPTH)+1  entries held
// - lap_overflow    out  1   sticky: lap dropped because FIFO full
// - time_wrap       out  1   sticky: time wrapped 99:59:59.99 -> 0
// BEHAVIOUR
// - Reset (async assert, sync deassert outside block): time_bcd=0, running=0, FIFO empty, lap_count=0,
//   lap_valid=0, lap_bcd=0, lap_overflow=0, time_wrap=0, prescaler=0, debouncers idle at level 0.
// - Buttons: 2-FF synchroniser, then debounce; one-cycle press pulse on accepted rising level.
//   Raw edge -> pulse latency = 2 + DEBOUNCE_CYCLES cycles; bounces shorter than DEBOUNCE_CYCLES ignored; release not an event.
// - Prescaler: counts 0..DIV-1 only while running; tick when it equals DIV-1, then returns to 0.
//   Cleared to 0 on every start press, so first increment lands exactly DIV cycles after start pulse.
//   Stop freezes time_bcd at once; partial prescaler count discarded.
// - Increment on tick: c 00..99, S 00..59, M 00..59, H 00..99, digit-wise BCD carry; all in one cycle.
//   99:59:59.99 + tick -> 00:00:00.00, time_wrap set, keeps running.
// - lap_btn while running: push current time_bcd (pre-increment value if tick in same cycle).
//   FIFO full: entry dropped, contents unchanged, lap_overflow set.
// - lap_btn while stopped: time_bcd=0, prescaler=0, time_wrap cleared; FIFO and lap_overflow untouched.
// - Same-cycle start_stop and lap pulses: lap acts on pre-toggle running state, then running toggles.
//   Stopped+both: clear then start, so time_bcd counts from 0.
// - FIFO: first-word-fall-through; lap_bcd = head combinationally from registered storage.
//   lap_rd with lap_valid=0 ignored. Push+pop same cycle when full: push accepted (pop frees slot),
//   lap_count unchanged, no overflow. Push+pop when empty: push only.
// - lap_overflow cleared only by reset or a pop that leaves FIFO empty.
// STRUCTURE
// - Package stop_watch_pkg: BCD digit limits (99/59/59/99), time_bcd field offsets, DIV localparam function.
// - Sub-module btn_debounce (sync + debounce + press pulse), instanced twice.
// - Prescaler, BCD counter, control and FIFO inline in this module.
// TESTING (CLK_HZ=1000, TICK_HZ=100 -> DIV=10, DEBOUNCE_CYCLES=4, LAP_DEPTH=4)
// - Reset mid-count -> all outputs 0 same edge as reset_n low, before next clk edge.
// - Start pulse, run 1000 cycles -> time_bcd=32'h0000_0100 (1.00 s); stop, wait 50 cycles -> unchanged.
// - Bounce start_stop_btn 3-cycle glitches x5 -> running stays 0; clean hold 6 cycles -> running=1 after 2+4 cycles.
// - Preload 32'h9959_5999 via force, running, one tick -> 32'h0000_0000, time_wrap=1.
// - 5 laps while running, no reads -> lap_count=4, lap_overflow=1; pop 4 -> 4 captured values in order,
//   lap_valid=0, lap_overflow=0.
// - Stopped at 32'h0000_1234, both buttons same cycle -> time 0, running=1, no FIFO push.

Source files
------------

// File: rtl/stop_watch_pkg.sv
// rtl/stop_watch_pkg.sv - shared constants and helpers for the lap stopwatch
// Contents: BCD tens-digit limits per field, time_bcd field offsets,
//           tick divider calculation and a two-digit BCD increment helper.
package stop_watch_pkg;

  // Tens-digit limits per field; units always roll over at 9.
  localparam logic [3:0] CS_TENS_MAX  = 4'd9;  // centiseconds 00..99
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;  // seconds 00..59
  localparam logic [3:0] MIN_TENS_MAX = 4'd5;  // minutes 00..59
  localparam logic [3:0] HR_TENS_MAX  = 4'd9;  // hours 00..99

  // Bit offset of each two-digit field inside time_bcd.
  localparam int CS_LSB  = 0;
  localparam int SEC_LSB = 8;
  localparam int MIN_LSB = 16;
  localparam int HR_LSB  = 24;

  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Increment a two-digit BCD field; bit 8 of the result is the carry out
  // produced when the field rolls over from {tens_max,9} to 00.
  function automatic logic [8:0] bcd_pair_inc(input logic [7:0] pair,
                                              input logic [3:0] tens_max);
    logic [8:0] r;
    r = {1'b0, pair};
    if (pair[3:0] != 4'd9) begin
      r[3:0] = pair[3:0] + 4'd1;
    end else begin
      r[3:0] = 4'd0;
      if (pair[7:4] == tens_max) begin
        r[7:4] = 4'd0;
        r[8]   = 1'b1;
      end else begin
        r[7:4] = pair[7:4] + 4'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchroniser, debouncer and press pulse
// Ports: clk, reset_n (async active-low), btn (raw async input),
//        press (one-cycle pulse when a new high level is accepted).
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [CW-1:0] cnt;
  logic          accept;

  // cnt holds how many consecutive edges sync2 has already differed from the
  // accepted level; the edge that would make it DEBOUNCE_CYCLES accepts.
  assign accept = (sync2 != stable) && (cnt == CNT_LAST);
  assign press  = accept && sync2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (accept) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/stop_watch_lap.sv
// rtl/stop_watch_lap.sv - HH:MM:SS.cc BCD stopwatch with lap FIFO
// Ports: clk, reset_n (async active-low); start_stop_btn, lap_btn (raw
//        buttons); lap_rd (pop); time_bcd, running; lap_bcd, lap_valid,
//        lap_count, lap_overflow (FIFO head/status); time_wrap (sticky).
module stop_watch_lap
  import stop_watch_pkg::*;
#(
  parameter int CLK_HZ          = 100_000_000,
  parameter int TICK_HZ         = 100,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LAP_DEPTH       = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start_stop_btn,
  input  logic                       lap_btn,
  input  logic                       lap_rd,
  output logic [31:0]                time_bcd,
  output logic                       running,
  output logic [31:0]                lap_bcd,
  output logic                       lap_valid,
  output logic [$clog2(LAP_DEPTH):0] lap_count,
  output logic                       lap_overflow,
  output logic                       time_wrap
);

  localparam int DIV  = calc_div(CLK_HZ, TICK_HZ);
  localparam int PW   = $clog2(DIV);
  localparam int AW   = $clog2(LAP_DEPTH);
  localparam int CNTW = AW + 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(DIV - 1);
  localparam logic [CNTW-1:0] DEPTH_C    = CNTW'(LAP_DEPTH);

  logic            start_p;
  logic            lap_p;
  logic [31:0]     time_q;
  logic            running_q;
  logic            wrap_q;
  logic [PW-1:0]   presc;
  logic            tick;
  logic [8:0]      cs_inc;
  logic [8:0]      sec_inc;
  logic [8:0]      min_inc;
  logic [8:0]      hr_inc;
  logic [31:0]     time_inc;
  logic            lap_push;
  logic            lap_clear;
  logic [31:0]     mem [LAP_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CNTW-1:0] count_q;
  logic            overflow_q;
  logic            full;
  logic            pop;
  logic            push_ok;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_db (
    .clk     (clk),
    .reset_n (reset_n),
    .btn     (start_stop_btn),
    .press   (start_p)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lap_db (
    .clk     (clk),
    .reset_n (reset_n),
    .btn     (lap_btn),
    .press   (lap_p)
  );

  // Full ripple of digit carries, resolved within one cycle.
  assign cs_inc  = bcd_pair_inc(time_q[CS_LSB +: 8], CS_TENS_MAX);
  assign sec_inc = cs_inc[8]  ? bcd_pair_inc(time_q[SEC_LSB +: 8], SEC_TENS_MAX)
                              : {1'b0, time_q[SEC_LSB +: 8]};
  assign min_inc = sec_inc[8] ? bcd_pair_inc(time_q[MIN_LSB +: 8], MIN_TENS_MAX)
                              : {1'b0, time_q[MIN_LSB +: 8]};
  assign hr_inc  = min_inc[8] ? bcd_pair_inc(time_q[HR_LSB +: 8], HR_TENS_MAX)
                              : {1'b0, time_q[HR_LSB +: 8]};
  assign time_inc = {hr_inc[7:0], min_inc[7:0], sec_inc[7:0], cs_inc[7:0]};

  assign tick      = running_q && (presc == PRESC_LAST);
  // The lap button is interpreted against the running state before any
  // same-cycle start/stop toggle takes effect.
  assign lap_push  = lap_p && running_q;
  assign lap_clear = lap_p && !running_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      time_q    <= '0;
      running_q <= 1'b0;
      wrap_q    <= 1'b0;
      presc     <= '0;
    end else begin
      if (lap_clear) begin
        time_q <= '0;
        wrap_q <= 1'b0;
      end else if (tick && !start_p) begin
        // A stop press freezes the display on the edge it lands, so a tick
        // coinciding with it is dropped.
        time_q <= time_inc;
        if (hr_inc[8]) begin
          wrap_q <= 1'b1;
        end
      end

      if (start_p) begin
        running_q <= !running_q;
        presc     <= '0;
      end else if (lap_clear) begin
        presc <= '0;
      end else if (running_q) begin
        presc <= tick ? '0 : presc + PW'(1);
      end
    end
  end

  assign full    = (count_q == DEPTH_C);
  assign pop     = lap_rd && (count_q != '0);
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign push_ok = lap_push && (!full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= time_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push_ok && !pop) begin
        count_q <= count_q + CNTW'(1);
      end else if (pop && !push_ok) begin
        count_q <= count_q - CNTW'(1);
      end

      if (lap_push && !push_ok) begin
        overflow_q <= 1'b1;
      end else if (pop && !push_ok && (count_q == CNTW'(1))) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign time_bcd     = time_q;
  assign running      = running_q;
  assign time_wrap    = wrap_q;
  assign lap_valid    = (count_q != '0);
  assign lap_bcd      = lap_valid ? mem[rd_ptr] : '0;
  assign lap_count    = count_q;
  assign lap_overflow = overflow_q;

endmodule

// File: tb/tb_stop_watch_lap.sv
// tb/tb_stop_watch_lap.sv - self-checking bench for stop_watch_lap
module tb_stop_watch_lap;

  localparam int DIV = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start_stop_btn;
  logic        lap_btn;
  logic        lap_rd;
  logic [31:0] time_bcd;
  logic        running;
  logic [31:0] lap_bcd;
  logic        lap_valid;
  logic [2:0]  lap_count;
  logic        lap_overflow;
  logic        time_wrap;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: elapsed centiseconds from the last start edge.
  int          base_cs    = 0;
  int          run_start  = 0;
  bit          m_running  = 0;
  logic [31:0] lap_q[$];

  stop_watch_lap #(
    .CLK_HZ(1000), .TICK_HZ(100), .DEBOUNCE_CYCLES(4), .LAP_DEPTH(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start_stop_btn(start_stop_btn),
    .lap_btn(lap_btn), .lap_rd(lap_rd), .time_bcd(time_bcd),
    .running(running), .lap_bcd(lap_bcd), .lap_valid(lap_valid),
    .lap_count(lap_count), .lap_overflow(lap_overflow), .time_wrap(time_wrap)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] to_bcd(input int cs);
    int c, s, m, h;
    c = cs % 100;
    s = (cs / 100) % 60;
    m = (cs / 6000) % 60;
    h = (cs / 360000) % 100;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
            4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  function automatic int model_cs(input int t);
    return m_running ? base_cs + (t - run_start) / DIV : base_cs;
  endfunction

  // Raw press starts now; the debounced action lands on edge eff.
  task automatic btn_down(input logic s, input logic l, output int eff);
    start_stop_btn = s;
    lap_btn        = l;
    eff            = cyc + 6;
  endtask

  task automatic btn_up(input int eff);
    while (cyc < eff) @(negedge clk);
    start_stop_btn = 1'b0;
    lap_btn        = 1'b0;
    repeat (7) @(negedge clk);
  endtask

  task automatic press(input logic s, input logic l, output int eff);
    btn_down(s, l, eff);
    btn_up(eff);
  endtask

  task automatic model_start(input int e);
    run_start = e;
    m_running = 1;
  endtask

  task automatic model_stop(input int e);
    base_cs   = model_cs(e - 1);
    m_running = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (time_bcd !== 32'h0) begin n_fail++; $display("FAIL reset_time: got %h expected %h", time_bcd, 32'h0); end
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %b expected 0", running); end
    n_checks++; if (lap_valid !== 1'b0 || lap_count !== 3'd0) begin n_fail++; $display("FAIL reset_fifo: got valid %b count %0d expected 0 0", lap_valid, lap_count); end
    n_checks++; if (lap_bcd !== 32'h0) begin n_fail++; $display("FAIL reset_lap_bcd: got %h expected 0", lap_bcd); end
    n_checks++; if (lap_overflow !== 1'b0 || time_wrap !== 1'b0) begin n_fail++; $display("FAIL reset_sticky: got ovf %b wrap %b expected 0 0", lap_overflow, time_wrap); end
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++; if (time_bcd !== 32'h0 || running !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: got %h run %b expected 0 0", time_bcd, running); end
  endtask

  task automatic test_run_stop();
    int e, s;
    press(1'b1, 1'b0, e);
    model_start(e);
    while (cyc < e + 1000) @(negedge clk);
    n_checks++; if (time_bcd !== 32'h0000_0100) begin n_fail++; $display("FAIL run_1000: got %h expected %h", time_bcd, 32'h0000_0100); end
    n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL run_running: got %b expected 1", running); end
    repeat ($urandom_range(0, 40)) @(negedge clk);
    press(1'b1, 1'b0, s);
    model_stop(s);
    n_checks++; if (time_bcd !== to_bcd(base_cs)) begin n_fail++; $display("FAIL stop_freeze: got %h expected %h", time_bcd, to_bcd(base_cs)); end
    repeat (50) @(negedge clk);
    n_checks++; if (time_bcd !== to_bcd(base_cs) || running !== 1'b0) begin n_fail++; $display("FAIL stop_hold: got %h run %b expected %h 0", time_bcd, running, to_bcd(base_cs)); end
  endtask

  task automatic test_bounce();
    bit seen = 0;
    int c, s;
    repeat (5) begin
      start_stop_btn = 1'b1;
      repeat (3) begin @(negedge clk); seen |= running; end
      start_stop_btn = 1'b0;
      repeat (3) begin @(negedge clk); seen |= running; end
    end
    repeat (8) begin @(negedge clk); seen |= running; end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL bounce_ignored: got running seen %b expected 0", seen); end
    c = cyc;
    start_stop_btn = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL debounce_early: got %b expected 0", running); end
    @(negedge clk);
    n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL debounce_latency: got %b expected 1", running); end
    start_stop_btn = 1'b0;
    model_start(c + 6);
    repeat (7 + $urandom_range(0, 60)) @(negedge clk);
    press(1'b1, 1'b0, s);
    model_stop(s);
    n_checks++; if (time_bcd !== to_bcd(base_cs)) begin n_fail++; $display("FAIL resume_accumulate: got %h expected %h", time_bcd, to_bcd(base_cs)); end
  endtask

  task automatic test_clear_and_wrap();
    int e, s;
    press(1'b0, 1'b1, e);
    base_cs = 0;
    n_checks++; if (time_bcd !== 32'h0) begin n_fail++; $display("FAIL lap_clear: got %h expected 0", time_bcd); end
    force dut.time_q = 32'h9959_5999;
    @(negedge clk);
    release dut.time_q;
    @(negedge clk);
    btn_down(1'b1, 1'b0, e);
    btn_up(e);
    while (cyc < e + DIV - 1) @(negedge clk);
    n_checks++; if (time_bcd !== 32'h9959_5999 || time_wrap !== 1'b0) begin n_fail++; $display("FAIL pre_wrap: got %h wrap %b expected 99595999 0", time_bcd, time_wrap); end
    @(negedge clk);
    n_checks++; if (time_bcd !== 32'h0 || time_wrap !== 1'b1 || running !== 1'b1) begin n_fail++; $display("FAIL wrap: got %h wrap %b run %b expected 0 1 1", time_bcd, time_wrap, running); end
    press(1'b1, 1'b0, s);
    press(1'b0, 1'b1, e);
    base_cs   = 0;
    m_running = 0;
    n_checks++; if (time_bcd !== 32'h0 || time_wrap !== 1'b0 || lap_count !== 3'd0) begin n_fail++; $display("FAIL clear_wrap: got %h wrap %b cnt %0d expected 0 0 0", time_bcd, time_wrap, lap_count); end
  endtask

  task automatic test_lap_fifo();
    int e, l;
    bit ovf = 0;
    press(1'b1, 1'b0, e);
    model_start(e);
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(0, 25)) @(negedge clk);
      press(1'b0, 1'b1, l);
      if (lap_q.size() < 4) lap_q.push_back(to_bcd(model_cs(l - 1)));
      else ovf = 1;
    end
    n_checks++; if (lap_count !== 3'(lap_q.size()) || lap_valid !== 1'b1) begin n_fail++; $display("FAIL fifo_fill: got cnt %0d valid %b expected %0d 1", lap_count, lap_valid, lap_q.size()); end
    n_checks++; if (lap_overflow !== ovf) begin n_fail++; $display("FAIL fifo_overflow: got %b expected %b", lap_overflow, ovf); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (lap_bcd !== lap_q[0]) begin n_fail++; $display("FAIL lap_pop%0d: got %h expected %h", i, lap_bcd, lap_q[0]); end
      void'(lap_q.pop_front());
      lap_rd = 1'b1;
      @(negedge clk);
      lap_rd = 1'b0;
    end
    n_checks++; if (lap_valid !== 1'b0 || lap_count !== 3'd0 || lap_overflow !== 1'b0) begin n_fail++; $display("FAIL fifo_drained: got valid %b cnt %0d ovf %b expected 0 0 0", lap_valid, lap_count, lap_overflow); end
    lap_rd = 1'b1;
    @(negedge clk);
    lap_rd = 1'b0;
    n_checks++; if (lap_count !== 3'd0 || lap_valid !== 1'b0) begin n_fail++; $display("FAIL pop_empty: got cnt %0d valid %b expected 0 0", lap_count, lap_valid); end
  endtask

  task automatic test_push_pop_full();
    int l;
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 15)) @(negedge clk);
      press(1'b0, 1'b1, l);
      lap_q.push_back(to_bcd(model_cs(l - 1)));
    end
    n_checks++; if (lap_count !== 3'd4) begin n_fail++; $display("FAIL refill: got %0d expected 4", lap_count); end
    btn_down(1'b0, 1'b1, l);
    while (cyc < l - 1) @(negedge clk);
    n_checks++; if (lap_bcd !== lap_q[0]) begin n_fail++; $display("FAIL full_head: got %h expected %h", lap_bcd, lap_q[0]); end
    lap_rd = 1'b1;
    @(negedge clk);
    lap_rd = 1'b0;
    void'(lap_q.pop_front());
    lap_q.push_back(to_bcd(model_cs(l - 1)));
    btn_up(l);
    n_checks++; if (lap_count !== 3'd4 || lap_overflow !== 1'b0) begin n_fail++; $display("FAIL full_push_pop: got cnt %0d ovf %b expected 4 0", lap_count, lap_overflow); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (lap_bcd !== lap_q[0]) begin n_fail++; $display("FAIL full_pop%0d: got %h expected %h", i, lap_bcd, lap_q[0]); end
      void'(lap_q.pop_front());
      lap_rd = 1'b1;
      @(negedge clk);
      lap_rd = 1'b0;
    end
  endtask

  task automatic test_both_buttons();
    int s, e;
    press(1'b1, 1'b0, s);
    model_stop(s);
    force dut.time_q = 32'h0000_1234;
    @(negedge clk);
    release dut.time_q;
    @(negedge clk);
    btn_down(1'b1, 1'b1, e);
    btn_up(e);
    base_cs = 0;
    model_start(e);
    n_checks++; if (time_bcd !== 32'h0 || running !== 1'b1 || lap_count !== 3'd0) begin n_fail++; $display("FAIL both_buttons: got %h run %b cnt %0d expected 0 1 0", time_bcd, running, lap_count); end
    while (cyc < e + DIV) @(negedge clk);
    n_checks++; if (time_bcd !== to_bcd(model_cs(cyc))) begin n_fail++; $display("FAIL both_first_tick: got %h expected %h", time_bcd, to_bcd(model_cs(cyc))); end
  endtask

  task automatic test_reset_mid_count();
    int l;
    press(1'b0, 1'b1, l);
    repeat ($urandom_range(3, 30)) @(negedge clk);
    n_checks++; if (lap_count !== 3'd1 || time_bcd !== to_bcd(model_cs(cyc))) begin n_fail++; $display("FAIL pre_reset: got cnt %0d time %h expected 1 %h", lap_count, time_bcd, to_bcd(model_cs(cyc))); end
    reset_n = 1'b0;
    #1;
    n_checks++; if (time_bcd !== 32'h0 || running !== 1'b0 || time_wrap !== 1'b0) begin n_fail++; $display("FAIL async_reset_time: got %h run %b wrap %b expected 0 0 0", time_bcd, running, time_wrap); end
    n_checks++; if (lap_count !== 3'd0 || lap_valid !== 1'b0 || lap_bcd !== 32'h0 || lap_overflow !== 1'b0) begin n_fail++; $display("FAIL async_reset_fifo: got cnt %0d valid %b bcd %h ovf %b expected 0 0 0 0", lap_count, lap_valid, lap_bcd, lap_overflow); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    reset_n        = 1'b0;
    start_stop_btn = 1'b0;
    lap_btn        = 1'b0;
    lap_rd         = 1'b0;
    test_reset();
    test_run_stop();
    test_bounce();
    test_clear_and_wrap();
    test_lap_fifo();
    test_push_pop_full();
    test_both_buttons();
    test_reset_mid_count();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
